// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one combinational ALU between two requesters.
// Operands are registered toward the ALU; the result and status are captured and returned on a per-port response handshake.
module alu_arbiter #(
  parameter int WIDTH  = 32,
  parameter int CTRL_W = 4,
  parameter int STAT_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [CTRL_W-1:0] req0_control,
  input  logic [WIDTH-1:0]  req0_op1,
  input  logic [WIDTH-1:0]  req0_op2,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [CTRL_W-1:0] req1_control,
  input  logic [WIDTH-1:0]  req1_op1,
  input  logic [WIDTH-1:0]  req1_op2,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [WIDTH-1:0]  rsp_result,
  output logic [STAT_W-1:0] rsp_status,
  output logic [CTRL_W-1:0] alu_control,
  output logic [WIDTH-1:0]  alu_operand_1,
  output logic [WIDTH-1:0]  alu_operand_2,
  input  logic [WIDTH-1:0]  alu_result,
  input  logic [STAT_W-1:0] alu_status,
  output logic              busy,
  output logic [CNT_W-1:0]  done_count
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  logic [1:0] state_r;
  logic [1:0] state_nxt_s;
  logic       last_grant_r;
  logic       owner_r;
  logic       grant_s;
  logic       accept_s;
  logic       owner_ready_s;
  logic       rsp_hs_s;
  logic       rsp0_valid_r;
  logic       rsp1_valid_r;
  logic       busy_r;

  // Grant selection: a single requester wins outright, a tie goes to the port not served last.
  always_comb begin
    grant_s = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_s = ~last_grant_r;
    end else if (req1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  assign accept_s      = (state_r == ST_IDLE) && (req0_valid || req1_valid);
  assign owner_ready_s = owner_r ? rsp1_ready : rsp0_ready;
  assign rsp_hs_s      = (state_r == ST_RESP) && owner_ready_s;

  // Ready is forced low while reset is asserted so no acceptance is signalled from a held-reset IDLE.
  assign req0_ready = rst_n && accept_s && (grant_s == 1'b0);
  assign req1_ready = rst_n && accept_s && (grant_s == 1'b1);

  // Next-state decode for IDLE -> EXEC -> RESP.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_EXEC;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_EXEC: state_nxt_s = ST_RESP;
      ST_RESP: begin
        if (rsp_hs_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_RESP;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // State, owner and round-robin history; last_grant resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      owner_r      <= 1'b0;
      last_grant_r <= 1'b1;
    end else begin
      state_r <= state_nxt_s;
      if (accept_s) begin
        owner_r <= grant_s;
      end
      if (rsp_hs_s) begin
        last_grant_r <= owner_r;
      end
    end
  end

  // Operand registers toward the ALU, loaded only on acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_control   <= {CTRL_W{1'b0}};
      alu_operand_1 <= {WIDTH{1'b0}};
      alu_operand_2 <= {WIDTH{1'b0}};
    end else if (accept_s) begin
      if (grant_s) begin
        alu_control   <= req1_control;
        alu_operand_1 <= req1_op1;
        alu_operand_2 <= req1_op2;
      end else begin
        alu_control   <= req0_control;
        alu_operand_1 <= req0_op1;
        alu_operand_2 <= req0_op2;
      end
    end
  end

  // Capture the settled ALU outputs at the end of the EXEC cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_result <= {WIDTH{1'b0}};
      rsp_status <= {STAT_W{1'b0}};
    end else if (state_r == ST_EXEC) begin
      rsp_result <= alu_result;
      rsp_status <= alu_status;
    end
  end

  // Registered response valids and busy flag, tracking the FSM transitions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid_r <= 1'b0;
      rsp1_valid_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      if (state_r == ST_EXEC) begin
        rsp0_valid_r <= ~owner_r;
        rsp1_valid_r <= owner_r;
      end else if (rsp_hs_s) begin
        rsp0_valid_r <= 1'b0;
        rsp1_valid_r <= 1'b0;
      end
      if (accept_s) begin
        busy_r <= 1'b1;
      end else if (rsp_hs_s) begin
        busy_r <= 1'b0;
      end
    end
  end

  // Completed-handshake counter, wrapping naturally at its width.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_count <= {CNT_W{1'b0}};
    end else if (rsp_hs_s) begin
      done_count <= done_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign rsp0_valid = rsp0_valid_r;
  assign rsp1_valid = rsp1_valid_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: transaction-level reference model with randomized traffic and a simple attached ALU.
module tb_alu_arbiter;
  localparam int WIDTH  = 32;
  localparam int CTRL_W = 4;
  localparam int STAT_W = 8;
  localparam int CNT_W  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid = 1'b0, req1_valid = 1'b0;
  logic req0_ready, req1_ready;
  logic [CTRL_W-1:0] req0_control = '0, req1_control = '0;
  logic [WIDTH-1:0] req0_op1 = '0, req0_op2 = '0, req1_op1 = '0, req1_op2 = '0;
  logic rsp0_valid, rsp1_valid;
  logic rsp0_ready = 1'b0, rsp1_ready = 1'b0;
  logic [WIDTH-1:0] rsp_result;
  logic [STAT_W-1:0] rsp_status;
  logic [CTRL_W-1:0] alu_control;
  logic [WIDTH-1:0] alu_operand_1, alu_operand_2, alu_result;
  logic [STAT_W-1:0] alu_status;
  logic busy;
  logic [CNT_W-1:0] done_count;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit lg_m = 1'b1;
  logic [CNT_W-1:0] cnt_m = '0;
  logic [CTRL_W-1:0] c_m [2];
  logic [WIDTH-1:0] a_m [2];
  logic [WIDTH-1:0] b_m [2];
  logic obs_owner;
  logic [WIDTH-1:0] obs_result;

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] alu_res(input logic [CTRL_W-1:0] c, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    case (c)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      4'b1100: return ~(a | b);
      default: return a ^ b;
    endcase
  endfunction

  function automatic logic [STAT_W-1:0] alu_stat(input logic [CTRL_W-1:0] c, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] r;
    r = alu_res(c, a, b);
    return {r[WIDTH-1], (r == 32'd0), 2'b00, c};
  endfunction

  assign alu_result = alu_res(alu_control, alu_operand_1, alu_operand_2);
  assign alu_status = alu_stat(alu_control, alu_operand_1, alu_operand_2);

  alu_arbiter #(.WIDTH(WIDTH), .CTRL_W(CTRL_W), .STAT_W(STAT_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_control(req0_control),
    .req0_op1(req0_op1), .req0_op2(req0_op2),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_control(req1_control),
    .req1_op1(req1_op1), .req1_op2(req1_op2),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_status(rsp_status),
    .alu_control(alu_control), .alu_operand_1(alu_operand_1), .alu_operand_2(alu_operand_2),
    .alu_result(alu_result), .alu_status(alu_status),
    .busy(busy), .done_count(done_count)
  );

  task automatic rand_port(input int p);
    c_m[p] = 4'($urandom_range(0, 15));
    a_m[p] = $urandom;
    b_m[p] = $urandom;
  endtask

  task automatic drive_ops();
    req0_control = c_m[0]; req0_op1 = a_m[0]; req0_op2 = b_m[0];
    req1_control = c_m[1]; req1_op1 = a_m[1]; req1_op2 = b_m[1];
  endtask

  task automatic do_reset();
    req0_valid = 1'b0; req1_valid = 1'b0; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    rst_n = 1'b0;
    lg_m = 1'b1;
    cnt_m = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  // One full operation starting in IDLE; checks grant, operands, response, backpressure and completion.
  task automatic do_op(input string nm, input bit v0, input bit v1, input int stall, input bit wrong_rdy, input bit hold_other);
    bit g;
    logic [WIDTH-1:0] er;
    logic [STAT_W-1:0] es;
    drive_ops();
    req0_valid = v0; req1_valid = v1; rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    #1;
    g = (v0 && v1) ? ~lg_m : v1;
    obs_owner = req1_ready;
    checks++;
    if (req0_ready !== ~g || req1_ready !== g || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s grant: rdy0=%b rdy1=%b busy=%b exp rdy0=%b rdy1=%b busy=0", nm, req0_ready, req1_ready, busy, ~g, g);
    end
    @(posedge clk); #1;
    checks++;
    if (busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 ||
        alu_control !== c_m[g] || alu_operand_1 !== a_m[g] || alu_operand_2 !== b_m[g]) begin
      errors++;
      $display("FAIL %s exec: busy=%b rdy=%b%b rspv=%b%b alu=%h/%h/%h exp alu=%h/%h/%h", nm, busy, req0_ready, req1_ready,
               rsp0_valid, rsp1_valid, alu_control, alu_operand_1, alu_operand_2, c_m[g], a_m[g], b_m[g]);
    end
    if (g) begin req1_valid = 1'b0; req0_valid = hold_other; end
    else   begin req0_valid = 1'b0; req1_valid = hold_other; end
    er = alu_res(c_m[g], a_m[g], b_m[g]);
    es = alu_stat(c_m[g], a_m[g], b_m[g]);
    @(posedge clk); #1;
    obs_result = rsp_result;
    checks++;
    if (rsp0_valid !== ~g || rsp1_valid !== g || rsp_result !== er || rsp_status !== es || done_count !== cnt_m) begin
      errors++;
      $display("FAIL %s resp: v=%b%b res=%h st=%h cnt=%0d exp v=%b%b res=%h st=%h cnt=%0d", nm, rsp0_valid, rsp1_valid,
               rsp_result, rsp_status, done_count, ~g, g, er, es, cnt_m);
    end
    for (int i = 0; i < stall; i++) begin
      if (g) rsp0_ready = wrong_rdy; else rsp1_ready = wrong_rdy;
      @(posedge clk); #1;
      checks++;
      if (rsp0_valid !== ~g || rsp1_valid !== g || rsp_result !== er || rsp_status !== es || done_count !== cnt_m ||
          busy !== 1'b1 || req0_ready !== 1'b0 || req1_ready !== 1'b0 || alu_control !== c_m[g] ||
          alu_operand_1 !== a_m[g] || alu_operand_2 !== b_m[g]) begin
        errors++;
        $display("FAIL %s stall%0d: v=%b%b res=%h cnt=%0d busy=%b rdy=%b%b exp v=%b%b res=%h cnt=%0d", nm, i,
                 rsp0_valid, rsp1_valid, rsp_result, done_count, busy, req0_ready, req1_ready, ~g, g, er, cnt_m);
      end
    end
    if (g) begin rsp1_ready = 1'b1; rsp0_ready = 1'b0; end
    else   begin rsp0_ready = 1'b1; rsp1_ready = 1'b0; end
    @(posedge clk); #1;
    cnt_m = cnt_m + 1'b1;
    lg_m = g;
    checks++;
    if (busy !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || done_count !== cnt_m) begin
      errors++;
      $display("FAIL %s done: busy=%b v=%b%b cnt=%0d exp busy=0 v=00 cnt=%0d", nm, busy, rsp0_valid, rsp1_valid, done_count, cnt_m);
    end
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0 ||
        alu_control !== 4'h0 || alu_operand_1 !== 32'h0 || alu_operand_2 !== 32'h0 || rsp_result !== 32'h0 ||
        rsp_status !== 8'h0 || done_count !== 2'd0) begin
      errors++;
      $display("FAIL reset: rdy=%b%b v=%b%b busy=%b alu=%h/%h/%h res=%h st=%h cnt=%0d exp all zero", req0_ready, req1_ready,
               rsp0_valid, rsp1_valid, busy, alu_control, alu_operand_1, alu_operand_2, rsp_result, rsp_status, done_count);
    end
    do_reset();
  endtask

  task automatic test_single_add();
    c_m[0] = 4'b0010; a_m[0] = 32'h229; b_m[0] = 32'h2EC2;
    rand_port(1);
    do_op("single_add", 1'b1, 1'b0, 0, 1'b0, 1'b0);
    checks++;
    if (obs_result !== 32'h30EB || done_count !== 2'd1) begin
      errors++;
      $display("FAIL single_add value: res=%h cnt=%0d exp res=30eb cnt=1", obs_result, done_count);
    end
  endtask

  task automatic test_tie();
    logic [3:0] exp_seq;
    exp_seq = 4'b1010;
    do_reset();
    rand_port(0); rand_port(1);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) rand_port(lg_m);
      do_op("tie", 1'b1, 1'b1, $urandom_range(0, 2), 1'b0, (i < 3));
      checks++;
      if (obs_owner !== exp_seq[i]) begin
        errors++;
        $display("FAIL tie order %0d: got port %b exp port %b", i, obs_owner, exp_seq[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    c_m[1] = 4'b0110; a_m[1] = 32'h2EC2; b_m[1] = 32'h229;
    rand_port(0);
    do_op("backpressure", 1'b0, 1'b1, 5, 1'b0, 1'b1);
    checks++;
    if (obs_result !== 32'h2C99) begin
      errors++;
      $display("FAIL backpressure value: res=%h exp 2c99", obs_result);
    end
    do_op("after_bp", 1'b1, 1'b0, 0, 1'b0, 1'b0);
  endtask

  task automatic test_wrong_port();
    rand_port(0);
    do_op("wrong_port", 1'b1, 1'b0, 4, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    int held;
    logic [1:0] v;
    held = -1;
    for (int i = 0; i < 24; i++) begin
      v = 2'($urandom_range(1, 3));
      if (held >= 0) v[held] = 1'b1;
      if (held != 0) rand_port(0);
      if (held != 1) rand_port(1);
      do_op("random", v[0], v[1], $urandom_range(0, 3), 1'($urandom_range(0, 1)), (i < 23) ? 1'($urandom_range(0, 1)) : 1'b0);
      held = (req0_valid === 1'b1) ? 0 : ((req1_valid === 1'b1) ? 1 : -1);
    end
  endtask

  task automatic test_reset_mid();
    rand_port(0); rand_port(1);
    drive_ops();
    req0_valid = 1'b1; req1_valid = 1'b0;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (rsp0_valid !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid setup: rsp0_valid=%b exp 1", rsp0_valid);
    end
    req0_valid = 1'b1; req1_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    lg_m = 1'b1;
    cnt_m = '0;
    checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0 || busy !== 1'b0 ||
        alu_control !== 4'h0 || alu_operand_1 !== 32'h0 || alu_operand_2 !== 32'h0 || rsp_result !== 32'h0 ||
        rsp_status !== 8'h0 || done_count !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid: rdy=%b%b v=%b%b busy=%b alu=%h res=%h cnt=%0d exp all zero", req0_ready, req1_ready,
               rsp0_valid, rsp1_valid, busy, alu_control, rsp_result, done_count);
    end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    do_op("after_reset", 1'b1, 1'b1, 0, 1'b0, 1'b0);
    checks++;
    if (obs_owner !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid grant: got port %b exp port 0", obs_owner);
    end
  endtask

  task automatic test_wrap();
    logic [CNT_W-1:0] wrap_seq [5];
    wrap_seq = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      rand_port(0); rand_port(1);
      do_op("wrap", 1'($urandom_range(0, 1)), 1'b1, 0, 1'b0, 1'b0);
      checks++;
      if (done_count !== wrap_seq[i]) begin
        errors++;
        $display("FAIL wrap %0d: cnt=%0d exp %0d", i, done_count, wrap_seq[i]);
      end
    end
  endtask

  initial begin
    rand_port(0); rand_port(1);
    test_reset();
    test_single_add();
    test_tie();
    test_backpressure();
    test_wrong_port();
    test_random();
    test_reset_mid();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares the single combinational ALU (4-bit control, two 32-bit operands, 32-bit result, 8-bit status) between two requesters. The two requesters are the instruction-execute path (port 0) and the address/auxiliary path (port 1). Each requester hands over one operation with a valid/ready handshake. The block arbitrates round-robin, drives the ALU from registered operands, captures result and status, and returns them on a per-requester response handshake with backpressure.

## Interface
Parameters:
- WIDTH, 32, operand/result width
- CTRL_W, 4, ALU control width
- STAT_W, 8, ALU status width
- CNT_W, 16, completed-operation counter width

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  reset, asynchronous and active-low
- req0_valid / req1_valid  in  1  requester has an operation pending
- req0_ready / req1_ready  out  1  operation accepted this cycle
- req0_control / req1_control  in  CTRL_W  ALU control code
- req0_op1, req0_op2 / req1_op1, req1_op2  in  WIDTH  operands
- rsp0_valid / rsp1_valid  out  1  result available for that requester
- rsp0_ready / rsp1_ready  in  1  requester takes the result
- rsp_result  out  WIDTH  captured ALU result (shared bus; qualified by rspN_valid)
- rsp_status  out  STAT_W  captured ALU status (shared bus)
- alu_control  out  CTRL_W  to ALU control input
- alu_operand_1, alu_operand_2  out  WIDTH  to ALU operand inputs
- alu_result  in  WIDTH  from ALU
- alu_status  in  STAT_W  from ALU
- busy  out  1  state is not IDLE
- done_count  out  CNT_W  number of completed response handshakes, wraps modulo 2^CNT_W

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Compute grant from req0_valid/req1_valid.
  - If only one requester is valid, grant it.
  - If both are valid, grant the requester other than last_grant.
  - reqN_ready = (state==IDLE) && grant==N. It is combinational from valid; valid must not depend on ready.
  - On acceptance: latch control/op1/op2 of the granted port into the alu_* registers, record owner = grant, go to EXEC.
  - No valid: stay in IDLE; alu_* registers hold their values.
- EXEC: exactly one cycle. The ALU settles on the registered operands. Capture alu_result/alu_status into rsp_result/rsp_status at the end of the cycle. Go to RESP.
- RESP:
  - rsp{owner}_valid = 1; the other rspN_valid = 0.
  - rsp_result/rsp_status/alu_* stay stable until the handshake.
  - On rsp{owner}_ready: set last_grant = owner, done_count += 1, go to IDLE.
  - No new request is accepted in RESP.
- Operand and result widths pass through unmodified. The arbiter does not interpret the control code or status.
- Reset values:
  - state IDLE, last_grant = 1 (port 0 wins the first tie).
  - alu_control, alu_operand_1, alu_operand_2, rsp_result, rsp_status, done_count = 0.
  - All ready/valid outputs and busy = 0.

## Timing
- Accept edge at cycle N. EXEC during N+1. rsp_valid is high from cycle N+2.
- Minimum 3 cycles per operation: accept, EXEC, RESP with rsp_ready already high.
- Maximum throughput is one operation per 3 cycles.
- Back-to-back ties alternate grants 0,1,0,1.
- A requester holding valid while the other is served is accepted in the IDLE cycle immediately after the handshake.
- rsp_ready low holds RESP indefinitely with all outputs stable.
- rsp_ready asserted by the non-owner is ignored.
- reqN_ready is never high outside IDLE. Both readies are never high together.
- Asynchronous reset mid-EXEC or mid-RESP forces IDLE immediately. The in-flight result is discarded; no response is issued after reset.
- done_count wraps from 2^CNT_W-1 to 0.

## Test plan
- Single add:
  - Stimulus: req0 with control 4'b0010, op1 32'h229, op2 32'h2EC2; rsp0_ready held 1; ALU model attached.
  - Required: req0_ready high for one cycle; alu_* = 2/229/2EC2 from the next cycle; rsp0_valid 2 cycles after acceptance with rsp_result 32'h30EB; done_count = 1.
- Tie round-robin:
  - Stimulus: both ports valid continuously from reset.
  - Required: grants in order 0,1,0,1; each response goes only to the owner's rsp valid.
- Backpressure:
  - Stimulus: req1 subtract (4'b0110) 32'h2EC2 − 32'h229; rsp1_ready held low 5 cycles.
  - Required: rsp1_valid stays high with rsp_result 32'h2C99 stable; req0 not accepted until 1 cycle after the handshake.
- Wrong-port ready:
  - Stimulus: owner is port 0; rsp1_ready=1, rsp0_ready=0.
  - Required: state stays in RESP; done_count unchanged.
- Reset mid-RESP:
  - Stimulus: rst_n low during RESP.
  - Required: all outputs at reset values immediately; after release, next tie grants port 0.
- Counter wrap:
  - Stimulus: CNT_W=2, 5 operations.
  - Required: done_count sequence 1,2,3,0,1.
